// File: rtl/riscv_structures.sv
// Shared pipeline records and encodings for the RISC-V core stages.
//   ex_to_mem_s : instruction handed from execute to the memory stage
//   mem_to_wb_s : registered result handed from memory to writeback
//   mem_state_e : memory-stage FSM state
//   F3_*        : funct3 load/store size encodings
package riscv_structures;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
        logic            is_final;
    } ex_to_mem_s;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            reg_write;
        logic [XLEN-1:0] data;
        logic            is_final;
    } mem_to_wb_s;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0]: 00 byte, 01 half, anything else is
    // handled as a word (unknown encodings fall back to LW/SW).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction and sign/zero extension.
//   rdata_i  : full data word returned by memory
//   addr_i   : byte offset of the access within the word
//   funct3_i : load type (LB/LH/LW/LBU/LHU, others behave as LW)
//   data_o   : extended 32-bit load result
module load_align
    import riscv_structures::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   data_o = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  data_o = {24'd0, byte_lane};
            F3_LHU:  data_o = {16'd0, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: accepts one instruction from execute, performs loads
// and stores on a req/gnt/rvalid data memory, and retires a registered
// mem_to_wb record.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ex_to_mem       : instruction from execute (valid/ready with ex_ready)
//   ex_ready        : high only in IDLE
//   mem_to_wb       : retire record, valid for one cycle per instruction
//   misaligned      : pulses with the retire of a misaligned access
//   dmem_*          : registered memory request, gnt/rvalid/rdata responses
//   dbg_state_o     : current FSM state for observation
// Handshake: an instruction transfers on a cycle where ex_to_mem.valid and
// ex_ready are both high; a memory request transfers on a cycle where
// dmem_req and dmem_gnt are both high, and its fields never change while
// dmem_req is waiting for dmem_gnt.
module memory_stage
    import riscv_structures::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  ex_to_mem_s  ex_to_mem,
    output logic        ex_ready,
    output mem_to_wb_s  mem_to_wb,
    output logic        misaligned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output mem_state_e  dbg_state_o
);

    mem_state_e  state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        reg_write_q, is_final_q, is_load_q;
    logic        dmem_req_q, dmem_we_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q;
    logic [3:0]  dmem_be_q;
    mem_to_wb_s  wb_q, wb_d;
    logic        misaligned_q, misaligned_d;

    logic        is_mem_op, is_mis, start_req;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, load_data;

    always_comb begin
        is_mem_op = ex_to_mem.mem_read | ex_to_mem.mem_write;
        is_mis    = is_mem_op & is_misaligned(ex_to_mem.funct3, ex_to_mem.alu_result[1:0]);
        start_req = (state_q == MEM_IDLE) & ex_to_mem.valid & is_mem_op & ~is_mis;
    end

    // Store lane placement: data is replicated so the enabled lanes carry it.
    always_comb begin
        st_be    = 4'hF;
        st_wdata = ex_to_mem.store_data;
        case (ex_to_mem.funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_to_mem.alu_result[1:0];
                st_wdata = {4{ex_to_mem.store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << ex_to_mem.alu_result[1:0];
                st_wdata = {2{ex_to_mem.store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MEM_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (start_req)   state_d = MEM_REQ;
            MEM_REQ:  if (dmem_gnt)    state_d = is_load_q ? MEM_WAIT : MEM_IDLE;
            MEM_WAIT: if (dmem_rvalid) state_d = MEM_IDLE;
            default:                   state_d = MEM_IDLE;
        endcase
    end

    // Output logic: ready and the next retire record. A bubble keeps rd,
    // data and is_final from the previous retire.
    always_comb begin
        ex_ready          = (state_q == MEM_IDLE);
        wb_d              = wb_q;
        wb_d.valid        = 1'b0;
        wb_d.reg_write    = 1'b0;
        misaligned_d      = 1'b0;
        case (state_q)
            MEM_IDLE: if (ex_to_mem.valid && !start_req) begin
                wb_d.valid     = 1'b1;
                wb_d.rd        = ex_to_mem.rd;
                wb_d.reg_write = ex_to_mem.reg_write & ~is_mem_op;
                wb_d.data      = ex_to_mem.alu_result;
                wb_d.is_final  = ex_to_mem.is_final;
                misaligned_d   = is_mis;
            end
            MEM_REQ: if (dmem_gnt && !is_load_q) begin
                wb_d.valid     = 1'b1;
                wb_d.rd        = rd_q;
                wb_d.data      = addr_q;
                wb_d.is_final  = is_final_q;
            end
            MEM_WAIT: if (dmem_rvalid) begin
                wb_d.valid     = 1'b1;
                wb_d.rd        = rd_q;
                wb_d.reg_write = reg_write_q;
                wb_d.data      = load_data;
                wb_d.is_final  = is_final_q;
            end
            default: ;
        endcase
    end

    // Datapath and registered memory request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            is_final_q   <= 1'b0;
            is_load_q    <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            wb_q         <= '0;
            misaligned_q <= 1'b0;
        end else begin
            wb_q         <= wb_d;
            misaligned_q <= misaligned_d;
            if (start_req) begin
                addr_q       <= ex_to_mem.alu_result;
                funct3_q     <= ex_to_mem.funct3;
                rd_q         <= ex_to_mem.rd;
                reg_write_q  <= ex_to_mem.reg_write;
                is_final_q   <= ex_to_mem.is_final;
                // A read+write op is a load.
                is_load_q    <= ex_to_mem.mem_read;
                dmem_req_q   <= 1'b1;
                dmem_we_q    <= ~ex_to_mem.mem_read;
                dmem_addr_q  <= {ex_to_mem.alu_result[31:2], 2'b00};
                dmem_be_q    <= ex_to_mem.mem_read ? 4'hF : st_be;
                dmem_wdata_q <= ex_to_mem.mem_read ? 32'd0 : st_wdata;
            end else if (state_q == MEM_REQ && dmem_gnt) begin
                dmem_req_q   <= 1'b0;
            end
        end
    end

    assign mem_to_wb   = wb_q;
    assign misaligned  = misaligned_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_be     = dmem_be_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign dbg_state_o = state_q;

endmodule
